// File: rtl/byte_col_packer_if.sv
// byte_col_packer_if
//   Groups the byte-input stream and the column-output stream of
//   byte_col_packer into one bundle.
//   Byte side  : din[7:0], din_valid (to packer), din_ready (from packer)
//   Column side: col_out[31:0], col_valid, col_idx[1:0], col_last (from
//                packer), col_ready (to packer)
//   modport slave  : the packer itself
//   modport master : the surrounding datapath (byte source and column sink)
interface byte_col_packer_if;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] col_out;
  logic        col_valid;
  logic        col_ready;
  logic [1:0]  col_idx;
  logic        col_last;

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output col_out,
    output col_valid,
    input  col_ready,
    output col_idx,
    output col_last
  );

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  col_out,
    input  col_valid,
    output col_ready,
    input  col_idx,
    input  col_last
  );
endinterface

// File: rtl/byte_col_packer.sv
// byte_col_packer
//   Byte-serial to column converter for the AES byte-serial datapath.
//   Packs four accepted bytes into a 32-bit column and offers it on a
//   valid/ready interface, tracking the column index within a block.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-low reset
//     clr  - synchronous clear (drops partial column, pending output, index)
//     bus  - byte_col_packer_if.slave:
//              din/din_valid/din_ready        byte input stream
//              col_out/col_valid/col_ready    column output stream
//              col_idx                        column number within block
//              col_last                       col_valid on column COLS-1
//
//   Parameters:
//     COLS      - columns per block (2..4)
//     MSB_FIRST - 1: first byte lands in col_out[31:24]; 0: in col_out[7:0]
//
//   Build option:
//     AES_MIXCOL_EN - when defined, the completed column is passed through
//                     MixColumns before being registered into col_out.
module byte_col_packer #(
  parameter int COLS      = 4,
  parameter int MSB_FIRST = 1
) (
  input logic               clk,
  input logic               rst,
  input logic               clr,
  byte_col_packer_if.slave  bus
);

  localparam logic [1:0] LAST_IDX = 2'(COLS - 1);

  logic [31:0] acc;
  logic [31:0] acc_nxt;
  logic [31:0] col_load;
  logic [31:0] col_out_q;
  logic [1:0]  byte_cnt;
  logic [1:0]  col_idx_q;
  logic        col_valid_q;

  logic        din_ready_w;
  logic        accept;
  logic        drain;
  logic        complete;

`ifdef AES_MIXCOL_EN
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // r0 is always the first byte of the column, wherever MSB_FIRST puts it;
  // the result is written back into the same byte positions.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] r0, r1, r2, r3;
    logic [7:0] m0, m1, m2, m3;
    if (MSB_FIRST != 0) begin
      r0 = c[31:24]; r1 = c[23:16]; r2 = c[15:8];  r3 = c[7:0];
    end else begin
      r0 = c[7:0];   r1 = c[15:8];  r2 = c[23:16]; r3 = c[31:24];
    end
    m0 = xtime(r0) ^ xtime(r1) ^ r1 ^ r2 ^ r3;
    m1 = r0 ^ xtime(r1) ^ xtime(r2) ^ r2 ^ r3;
    m2 = r0 ^ r1 ^ xtime(r2) ^ xtime(r3) ^ r3;
    m3 = xtime(r0) ^ r0 ^ r1 ^ r2 ^ xtime(r3);
    if (MSB_FIRST != 0) return {m0, m1, m2, m3};
    else                return {m3, m2, m1, m0};
  endfunction
`endif

  // The fourth byte may only be taken if the output register is free or
  // being drained on the same edge; bytes 0-2 never conflict with it.
  assign din_ready_w = rst && !(byte_cnt == 2'd3 && col_valid_q && !bus.col_ready);
  assign accept      = bus.din_valid && din_ready_w;
  assign drain       = col_valid_q && bus.col_ready;
  assign complete    = accept && (byte_cnt == 2'd3);

  always_comb begin
    if (MSB_FIRST != 0) acc_nxt = {acc[23:0], bus.din};
    else                acc_nxt = {bus.din, acc[31:8]};
  end

  always_comb begin
`ifdef AES_MIXCOL_EN
    col_load = mix_column(acc_nxt);
`else
    col_load = acc_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc         <= '0;
      byte_cnt    <= '0;
      col_out_q   <= '0;
      col_valid_q <= 1'b0;
      col_idx_q   <= '0;
    end else if (clr) begin
      // col_out is intentionally left holding its last value
      acc         <= '0;
      byte_cnt    <= '0;
      col_valid_q <= 1'b0;
      col_idx_q   <= '0;
    end else begin
      if (accept) begin
        acc      <= acc_nxt;
        byte_cnt <= byte_cnt + 2'd1;
      end
      // A column completing on the drain edge keeps col_valid high and
      // picks up the index that the drain advances to.
      if (complete) begin
        col_out_q   <= col_load;
        col_valid_q <= 1'b1;
      end else if (drain) begin
        col_valid_q <= 1'b0;
      end
      if (drain) begin
        col_idx_q <= (col_idx_q == LAST_IDX) ? '0 : col_idx_q + 2'd1;
      end
    end
  end

  assign bus.din_ready = din_ready_w;
  assign bus.col_out   = col_out_q;
  assign bus.col_valid = col_valid_q;
  assign bus.col_idx   = col_idx_q;
  assign bus.col_last  = col_valid_q && (col_idx_q == LAST_IDX);

endmodule

// File: tb/tb_byte_col_packer.sv
module tb_byte_col_packer;

  localparam int COLS      = 4;
  localparam int MSB_FIRST = 1;

  logic clk;
  logic rst;
  logic clr;

  byte_col_packer_if bus ();

  byte_col_packer #(
    .COLS      (COLS),
    .MSB_FIRST (MSB_FIRST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bytes of the column being gathered, plus the column
  // currently offered downstream.
  logic [7:0]  part[$];
  logic        m_pending;
  int          m_idx;
  logic [31:0] m_out;

`ifdef AES_MIXCOL_EN
  function automatic int gmul(input int a, input int m);
    int r;
    int x;
    r = 0;
    x = a;
    if (m % 2 == 1) r = r ^ x;
    x = x * 2;
    if (x > 255) x = x ^ 'h11b;
    if ((m / 2) % 2 == 1) r = r ^ x;
    return r;
  endfunction
`endif

  function automatic logic [31:0] model_pack(input logic [7:0] p0, input logic [7:0] p1,
                                             input logic [7:0] p2, input logic [7:0] p3);
    int s[4];
    int r[4];
    int base[4];
    s[0] = p0; s[1] = p1; s[2] = p2; s[3] = p3;
    base[0] = 2; base[1] = 3; base[2] = 1; base[3] = 1;
    for (int i = 0; i < 4; i++) begin
      r[i] = s[i];
`ifdef AES_MIXCOL_EN
      r[i] = 0;
      for (int j = 0; j < 4; j++) r[i] = r[i] ^ gmul(s[j], base[(j - i + 4) % 4]);
`endif
    end
    if (MSB_FIRST != 0)
      return {8'(r[0]), 8'(r[1]), 8'(r[2]), 8'(r[3])};
    else
      return {8'(r[3]), 8'(r[2]), 8'(r[1]), 8'(r[0])};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    part.delete();
    m_pending = 1'b0;
    m_idx     = 0;
    m_out     = '0;
  endtask

  // One clock cycle: drive inputs, check outputs on the falling edge,
  // advance the model at the rising edge.
  task automatic step(input logic dv, input logic [7:0] d, input logic cr, input logic cl);
    logic exp_ready;
    logic take;
    bus.din_valid = dv;
    bus.din       = d;
    bus.col_ready = cr;
    clr           = cl;
    @(negedge clk);
    exp_ready = !(part.size() == 3 && m_pending && !cr);
    check("din_ready", 32'(bus.din_ready), 32'(exp_ready));
    check("col_valid", 32'(bus.col_valid), 32'(m_pending));
    check("col_idx",   32'(bus.col_idx),   32'(m_idx));
    check("col_last",  32'(bus.col_last),  32'(m_pending && m_idx == COLS - 1));
    check("col_out",   bus.col_out,        m_out);
    @(posedge clk);
    if (cl) begin
      part.delete();
      m_pending = 1'b0;
      m_idx     = 0;
    end else begin
      take = dv && exp_ready;
      if (m_pending && cr) begin
        m_pending = 1'b0;
        m_idx     = (m_idx + 1) % COLS;
      end
      if (take) begin
        part.push_back(d);
        if (part.size() == 4) begin
          m_out     = model_pack(part[0], part[1], part[2], part[3]);
          m_pending = 1'b1;
          part.delete();
        end
      end
    end
    #1;
  endtask

  task automatic feed4(input logic [31:0] w, input logic cr);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, t[31:24], cr, 1'b0);
      t = t << 8;
    end
  endtask

  initial begin
    rst           = 1'b0;
    clr           = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.col_ready = 1'b0;
    model_reset();

    // Reset state
    #2;
    check("rst_din_ready", 32'(bus.din_ready), 32'd0);
    check("rst_col_valid", 32'(bus.col_valid), 32'd0);
    check("rst_col_out",   bus.col_out,        32'd0);
    check("rst_col_idx",   32'(bus.col_idx),   32'd0);
    check("rst_col_last",  32'(bus.col_last),  32'd0);
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic pack
    feed4(32'hdb135345, 1'b1);
`ifndef AES_MIXCOL_EN
    check("basic_col_out", bus.col_out, 32'hdb135345);
`endif
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);

    // Full block back-to-back
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);

    // Backpressure: hold first column, bytes 4-6 still taken, byte 7 stalls
    for (int i = 0; i < 7; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h07, 1'b0, 1'b0);
    step(1'b1, 8'h07, 1'b0, 1'b0);
    step(1'b1, 8'h07, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);

    // clr mid-column drops the byte presented with it
    step(1'b1, 8'ha1, 1'b1, 1'b0);
    step(1'b1, 8'hb2, 1'b1, 1'b0);
    step(1'b1, 8'hc3, 1'b1, 1'b1);
    feed4(32'h11223344, 1'b1);
`ifndef AES_MIXCOL_EN
    check("clr_col_out", bus.col_out, 32'h11223344);
`endif
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) == 0);

    // Asynchronous reset while a column is pending
    step(1'b0, 8'h00, 1'b1, 1'b1);
    feed4(32'h5a6b7c8d, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    bus.din_valid = 1'b0;
    check("pre_rst_col_valid", 32'(bus.col_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst_col_valid", 32'(bus.col_valid), 32'd0);
    check("arst_col_out",   bus.col_out,        32'd0);
    check("arst_col_idx",   32'(bus.col_idx),   32'd0);
    check("arst_din_ready", 32'(bus.din_ready), 32'd0);
    check("arst_col_last",  32'(bus.col_last),  32'd0);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    feed4(32'h01020304, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef AES_MIXCOL_EN
    step(1'b0, 8'h00, 1'b1, 1'b1);
    feed4(32'hdb135345, 1'b1);
    check("mix1_col_out", bus.col_out, 32'h8e4da1bc);
    feed4(32'hf20a225c, 1'b1);
    check("mix2_col_out", bus.col_out, 32'h9fdc589d);
    step(1'b0, 8'h00, 1'b1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/byte_col_packer.md
Name: byte_col_packer

Overview:
- Byte-serial to column converter downstream of the 4-stage byte mux/shift register in the AES byte-serial datapath.
- Consumes one 8-bit state byte per accepted transfer and packs four consecutive bytes into a 32-bit column.
- Presents each column on a valid/ready interface to the column-wide stage (MixColumns/AddRoundKey).
- Tracks column position within a 128-bit block and flags the last column.

Parameters:
- COLS, 4, columns per block; col_idx wraps at COLS-1 and col_last marks it (legal 2..4).
- MSB_FIRST, 1, 1: first byte of a column lands in col_out[31:24]; 0: first byte lands in col_out[7:0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear: drops partial column, output column and indices
- din  input  8  byte from shift-register chain
- din_valid  input  1  din holds a byte
- din_ready  output  1  packer accepts din this cycle
- col_out  output  32  packed column
- col_valid  output  1  col_out valid
- col_ready  input  1  downstream accepts col_out
- col_idx  output  2  column number of col_out within block (0..COLS-1)
- col_last  output  1  col_valid && col_idx==COLS-1

Behaviour:
- Reset (rst low, async): acc=0, byte_cnt=0, col_out=0, col_valid=0, col_idx=0. With rst low: din_ready=0 and col_last=0. Outputs update immediately, clock-independent.
- Byte accept: din_valid && din_ready at a rising edge.
- Accumulator:
  - MSB_FIRST=1: acc={acc[23:0],din}.
  - MSB_FIRST=0: acc={din,acc[31:8]}.
  - byte_cnt increments 0..3 and wraps to 0.
- Column complete: a byte is accepted with byte_cnt==3. On the same edge the packed value, including that byte, loads col_out and col_valid=1.
- Latency: fourth byte accepted at edge N; col_valid is high from edge N, i.e. in the following cycle.
- Output handshake: col_valid && col_ready at an edge.
  - col_valid clears, unless a new column completes on the same edge.
  - col_idx increments, wrapping COLS-1 -> 0.
- din_ready = rst && !(byte_cnt==3 && col_valid && !col_ready).
  - Stalls only when the fourth byte would overwrite an undrained column.
  - Bytes 0-2 of the next column are always accepted while the output is held, so full throughput is one byte per cycle.
- Simultaneous completion and drain: col_out reloads and col_valid stays 1. col_idx increments once, and the new column carries the incremented index.
- col_out, col_idx and col_last stay stable while col_valid && !col_ready.
- clr (synchronous):
  - Has priority over all transfers on that edge.
  - acc, byte_cnt, col_valid and col_idx go to 0; col_out keeps its value.
  - din_ready stays per formula; a byte presented with clr is discarded.
- Mid-operation async reset: partial column and pending output are lost. The first byte after reset release starts a new column 0.
- din_valid low: no state change apart from the output handshake.

Optional Feature:
- Macro AES_MIXCOL_EN.
- Defined: the value loaded into col_out at column completion is MixColumns(packed column), computed combinationally before the register. Byte order is r0 = first byte. Uses the GF(2^8) xtime with polynomial 0x11B and row formula s'0=2s0^3s1^s2^s3, rotated per row. Latency and handshake are unchanged.
- Undefined: col_out is the raw packed column.

Test Plan:
- Basic pack (MSB_FIRST=1, macro off): bytes db,13,53,45 on consecutive cycles, col_ready=1 -> col_valid one cycle after byte 4, col_out=db135345, col_idx=0, col_last=0.
- Full block: 16 bytes 00..0f back-to-back, col_ready=1 -> four columns 00010203, 04050607, 08090a0b, 0c0d0e0f. col_idx 0..3, col_last only on the fourth, din_ready never drops.
- Backpressure: col_ready=0 after first column, continue feeding -> bytes 4-6 accepted. din_ready=0 with byte 7 presented; col_out held at 00010203. Raise col_ready -> byte 7 accepted on that edge, col_out=04050607, col_idx=1.
- clr mid-column: feed a1,b2, assert clr with c3 on din -> c3 dropped, byte_cnt=0. Next bytes 11,22,33,44 give col_out=11223344, col_idx=0.
- Async reset: assert rst low between clock edges while col_valid=1 -> col_valid, col_out, col_idx, din_ready go 0 immediately without a clock edge.
- AES_MIXCOL_EN defined: bytes db,13,53,45 -> col_out=8e4da1bc. Bytes f2,0a,22,5c -> col_out=9fdc589d.
